// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, fetches over a req/gnt + rvalid
// handshake, and presents either a fetched word or a bubble to the IF/ID register.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013,
   parameter logic [31:0] BUBBLE_PC4 = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_pc4_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc_q, pc_next;
   logic [31:0] inst_q, inst_next;
   logic        drop_q, drop_next;

   logic [31:0] pc_plus4;
   logic [31:0] target_pc;

   assign pc_plus4  = pc_q + 32'd4;
   assign target_pc = redirect_pc_i & ~32'd3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_BOOT;
         pc_q   <= RESET_PC;
         inst_q <= NOP_INST;
         drop_q <= 1'b0;
      end else begin
         state  <= state_next;
         pc_q   <= pc_next;
         inst_q <= inst_next;
         drop_q <= drop_next;
      end
   end

   always_comb begin
      state_next  = state;
      pc_next     = pc_q;
      inst_next   = inst_q;
      drop_next   = drop_q;
      imem_req_o  = 1'b0;
      imem_addr_o = pc_q;
      if_valid_o  = 1'b0;
      if_pc4_o    = BUBBLE_PC4;
      if_inst_o   = NOP_INST;

      case (state)
         S_BOOT: begin
            state_next = S_REQ;
         end

         S_REQ: begin
            imem_req_o = !redirect_i;
            if (redirect_i) begin
               pc_next = target_pc;
            end else if (imem_gnt_i) begin
               state_next = S_WAIT;
            end
         end

         S_WAIT: begin
            // A redirect with the response still in flight arms drop_q so that
            // the stale word is swallowed when it eventually returns.
            if (redirect_i) begin
               pc_next = target_pc;
               if (imem_rvalid_i) begin
                  drop_next  = 1'b0;
                  state_next = S_REQ;
               end else begin
                  drop_next = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (drop_q) begin
                  drop_next  = 1'b0;
                  state_next = S_REQ;
               end else begin
                  inst_next  = imem_rdata_i;
                  state_next = S_VALID;
               end
            end
         end

         S_VALID: begin
            if_valid_o = 1'b1;
            if_inst_o  = inst_q;
            if_pc4_o   = pc_plus4;
            if (redirect_i) begin
               pc_next    = target_pc;
               state_next = S_REQ;
            end else if (!stall_i) begin
               // Consumed: fetch the next sequential word in the same cycle.
               pc_next     = pc_plus4;
               imem_req_o  = 1'b1;
               imem_addr_o = pc_plus4;
               state_next  = imem_gnt_i ? S_WAIT : S_REQ;
            end
         end

         default: begin
            state_next = S_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a per-cycle vector table for the directed corner
// cases, a reset-in-flight sequence, then randomized traffic against a PC-stream model.
module tb_if_fetch_stage;

   localparam logic [31:0] BUB = 32'hFFFF_FF00;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic        L   = 1'b0;
   localparam logic        H   = 1'b1;
   localparam int          NV  = 38;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic [31:0] pc4;
   logic [31:0] inst;
   logic        valid;

   int tests;
   int fails;

   if_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .if_pc4_o      (pc4),
      .if_inst_o     (inst),
      .if_valid_o    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] inst;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                               input logic g, input logic v, input logic [31:0] rd,
                               input logic q, input logic [31:0] a, input logic ov,
                               input logic [31:0] p4, input logic [31:0] in);
      vec_t t;
      t.stall = s;  t.redirect = r; t.rpc = rpc;  t.gnt = g;  t.rvalid = v; t.rdata = rd;
      t.req = q;    t.addr = a;     t.valid = ov; t.pc4 = p4; t.inst = in;
      return t;
   endfunction

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at posedge+1 with reset released: the DUT is in its boot cycle.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("reset_req",   {31'b0, req},   32'h0);
      check("reset_valid", {31'b0, valid}, 32'h0);
      check("reset_pc4",   pc4,            BUB);
      check("reset_inst",  inst,           NOP);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic        pend;
      int          pcnt;
      logic [31:0] paddr;
      int          idle;

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      idle_inputs();

      // stall, redir, rpc, gnt, rvalid, rdata | req, addr, valid, pc4, inst
      vecs[0]  = mk(L, L, 32'h0,         L, L, 32'h0,         L, 32'h0,         L, BUB,          NOP);
      vecs[1]  = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h0,         L, BUB,          NOP);
      vecs[2]  = mk(L, L, 32'h0,         L, H, 32'hA000_0001, L, 32'h0,         L, BUB,          NOP);
      vecs[3]  = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h4,         H, 32'h4,        32'hA000_0001);
      vecs[4]  = mk(L, L, 32'h0,         L, H, 32'hA000_0002, L, 32'h0,         L, BUB,          NOP);
      vecs[5]  = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h8,         H, 32'h8,        32'hA000_0002);
      vecs[6]  = mk(L, L, 32'h0,         L, H, 32'hA000_0003, L, 32'h0,         L, BUB,          NOP);
      vecs[7]  = mk(H, L, 32'h0,         H, L, 32'h0,         L, 32'h0,         H, 32'hC,        32'hA000_0003);
      vecs[8]  = mk(H, L, 32'h0,         H, L, 32'h0,         L, 32'h0,         H, 32'hC,        32'hA000_0003);
      vecs[9]  = mk(H, L, 32'h0,         H, L, 32'h0,         L, 32'h0,         H, 32'hC,        32'hA000_0003);
      vecs[10] = mk(L, L, 32'h0,         L, L, 32'h0,         H, 32'hC,         H, 32'hC,        32'hA000_0003);
      vecs[11] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'hC,         L, BUB,          NOP);
      vecs[12] = mk(L, H, 32'h100,       L, L, 32'h0,         L, 32'h0,         L, BUB,          NOP);
      vecs[13] = mk(L, L, 32'h0,         L, L, 32'h0,         L, 32'h0,         L, BUB,          NOP);
      vecs[14] = mk(L, L, 32'h0,         L, H, 32'hDEAD_BEEF, L, 32'h0,         L, BUB,          NOP);
      vecs[15] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h100,       L, BUB,          NOP);
      vecs[16] = mk(L, L, 32'h0,         L, H, 32'hB000_0100, L, 32'h0,         L, BUB,          NOP);
      vecs[17] = mk(H, H, 32'h203,       L, L, 32'h0,         L, 32'h0,         H, 32'h104,      32'hB000_0100);
      vecs[18] = mk(L, L, 32'h0,         L, L, 32'h0,         H, 32'h200,       L, BUB,          NOP);
      vecs[19] = mk(L, L, 32'h0,         L, L, 32'h0,         H, 32'h200,       L, BUB,          NOP);
      vecs[20] = mk(L, L, 32'h0,         L, L, 32'h0,         H, 32'h200,       L, BUB,          NOP);
      vecs[21] = mk(L, L, 32'h0,         L, L, 32'h0,         H, 32'h200,       L, BUB,          NOP);
      vecs[22] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h200,       L, BUB,          NOP);
      vecs[23] = mk(L, L, 32'h0,         L, H, 32'hC000_0200, L, 32'h0,         L, BUB,          NOP);
      vecs[24] = mk(H, L, 32'h0,         L, L, 32'h0,         L, 32'h0,         H, 32'h204,      32'hC000_0200);
      vecs[25] = mk(H, H, 32'hFFFF_FFFE, L, L, 32'h0,         L, 32'h0,         H, 32'h204,      32'hC000_0200);
      vecs[26] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'hFFFF_FFFC, L, BUB,          NOP);
      vecs[27] = mk(L, L, 32'h0,         L, H, 32'hD000_0000, L, 32'h0,         L, BUB,          NOP);
      vecs[28] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h0,         H, 32'h0,        32'hD000_0000);
      vecs[29] = mk(L, H, 32'h40,        L, H, 32'h5555_5555, L, 32'h0,         L, BUB,          NOP);
      vecs[30] = mk(L, H, 32'h80,        H, L, 32'h0,         L, 32'h0,         L, BUB,          NOP);
      vecs[31] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h80,        L, BUB,          NOP);
      vecs[32] = mk(L, L, 32'h0,         L, L, 32'h0,         L, 32'h0,         L, BUB,          NOP);
      vecs[33] = mk(L, L, 32'h0,         L, H, 32'hE000_0080, L, 32'h0,         L, BUB,          NOP);
      vecs[34] = mk(L, L, 32'h0,         L, L, 32'h0,         H, 32'h84,        H, 32'h84,       32'hE000_0080);
      vecs[35] = mk(L, L, 32'h0,         L, H, 32'h1234_5678, H, 32'h84,        L, BUB,          NOP);
      vecs[36] = mk(L, L, 32'h0,         H, L, 32'h0,         H, 32'h84,        L, BUB,          NOP);
      vecs[37] = mk(L, L, 32'h0,         L, L, 32'h0,         L, 32'h0,         L, BUB,          NOP);

      do_reset();
      for (int i = 0; i < NV; i++) begin
         stall = vecs[i].stall;   redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
         gnt = vecs[i].gnt;       rvalid = vecs[i].rvalid;     rdata = vecs[i].rdata;
         @(negedge clk);
         $display("[TB] vec %0d req=%b addr=%h valid=%b pc4=%h inst=%h", i, req, addr, valid, pc4, inst);
         check($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, vecs[i].req});
         if (vecs[i].req) check($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
         check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
         check($sformatf("vec%0d_pc4", i), pc4, vecs[i].pc4);
         check($sformatf("vec%0d_inst", i), inst, vecs[i].inst);
         next_cycle();
      end

      // Reset pulsed while a fetch is outstanding; its response lands after release.
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("rst_mid_req",   {31'b0, req},   32'h0);
      check("rst_mid_valid", {31'b0, valid}, 32'h0);
      next_cycle();
      rst_n  = 1'b1;
      rvalid = 1'b1;
      rdata  = 32'h9999_9999;
      @(negedge clk);
      check("late_c1_req",   {31'b0, req},   32'h0);
      check("late_c1_valid", {31'b0, valid}, 32'h0);
      next_cycle();
      @(negedge clk);
      check("late_c2_req",   {31'b0, req},   32'h1);
      check("late_c2_addr",  addr,           32'h0);
      check("late_c2_valid", {31'b0, valid}, 32'h0);
      next_cycle();
      rvalid = 1'b0;
      @(negedge clk);
      check("late_c3_req",   {31'b0, req},   32'h1);
      check("late_c3_valid", {31'b0, valid}, 32'h0);
      $display("[TB] reset-in-flight req=%b addr=%h valid=%b", req, addr, valid);
      next_cycle();

      // Randomized traffic: the model tracks only the next PC the pipeline should see.
      do_reset();
      exp_pc = 32'h0;
      pend   = 1'b0;
      pcnt   = 0;
      paddr  = 32'h0;
      idle   = 0;
      for (int c = 0; c < 2500; c++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = (c >= 2) && ($urandom_range(0, 9) == 0);
         redirect_pc = $urandom;
         gnt         = ($urandom_range(0, 9) < 6);
         if (pend && pcnt == 1) begin
            rvalid = 1'b1;
            rdata  = mem_word(paddr);
         end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            if (pend) pcnt--;
         end
         @(negedge clk);

         if (valid) begin
            check("rnd_pc",   pc4 - 32'd4, exp_pc);
            check("rnd_inst", inst,        mem_word(pc4 - 32'd4));
            if (!stall && !redirect) begin
               $display("[TB] cycle %0d consume pc4=%h inst=%h", c, pc4, inst);
               exp_pc = exp_pc + 32'd4;
            end
            idle = 0;
         end else begin
            check("rnd_bub_pc4",  pc4,  BUB);
            check("rnd_bub_inst", inst, NOP);
            idle++;
         end
         if (redirect) exp_pc = redirect_pc & ~32'd3;
         if (rvalid) pend = 1'b0;
         if (req) begin
            check("rnd_req_redirect", {31'b0, redirect}, 32'h0);
            check("rnd_req_addr",     addr,              exp_pc);
            if (gnt) begin
               check("rnd_outstanding", {31'b0, pend}, 32'h0);
               pend  = 1'b1;
               pcnt  = $urandom_range(1, 3);
               paddr = addr;
            end
         end
         if (idle > 200) begin
            tests++;
            fails++;
            $display("FAIL rnd_progress: %0d cycles without an instruction, limit 200", idle);
            break;
         end
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
